// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy, threshold flags, sticky errors, flush and FWFT mode
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, din          write request and data
//   rd_en               read / pop request
//   flush               synchronous clear of contents (beats wr_en and rd_en)
//   clr_err             clears overflow/underflow
//   dout, rd_valid      read data and its qualifier (registered or FWFT)
//   full, empty         level == DEPTH, level == 0
//   almost_full         level >= AFULL_THRESH
//   almost_empty        level <= AEMPTY_THRESH
//   level               occupancy 0..DEPTH
//   overflow, underflow sticky error flags

module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LVL_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // level never exceeds DEPTH, so its MSB alone marks the full state
    assign full         = level_q[ADDR_WIDTH];
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AFULL_LVL);
    assign almost_empty = (level_q <= AEMPTY_LVL);
    assign level        = level_q;

    // Acceptance uses the pre-edge level: a write to a full FIFO is refused
    // even when a read frees a slot on the same edge.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky errors: a new error on the same edge as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full  && !flush);
            underflow <= (underflow && !clr_err) || (rd_en && empty && !flush);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always visible; rd_en only acknowledges it
            assign dout     = mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    // flush suppresses rd_acc, which also drops rd_valid
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign dout     = dout_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags in standard and FWFT modes

module tb_sync_fifo_flags;

    logic clk;
    logic rst_n;

    // standard-mode instance signals
    logic       s_wr, s_rd, s_flush, s_clr;
    logic [7:0] s_din, s_dout;
    logic       s_rv, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [4:0] s_level;

    // FWFT instance signals
    logic       f_wr, f_rd, f_flush, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_rv, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] f_level;

    int tests = 0;
    int fails = 0;

    // model of the standard instance
    logic [7:0] sb [$];
    int         m_lvl;
    logic       m_ovf, m_udf, m_rv;
    logic [7:0] m_dout;

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
        .flush(s_flush), .clr_err(s_clr), .dout(s_dout), .rd_valid(s_rv),
        .full(s_full), .empty(s_empty), .almost_full(s_afull),
        .almost_empty(s_aempty), .level(s_level), .overflow(s_ovf),
        .underflow(s_udf)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
        .flush(f_flush), .clr_err(f_clr), .dout(f_dout), .rd_valid(f_rv),
        .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .level(f_level), .overflow(f_ovf),
        .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_std(input string ctx);
        chk({ctx, ".level"},     32'(s_level),  32'(m_lvl));
        chk({ctx, ".full"},      32'(s_full),   32'(m_lvl == 16));
        chk({ctx, ".empty"},     32'(s_empty),  32'(m_lvl == 0));
        chk({ctx, ".afull"},     32'(s_afull),  32'(m_lvl >= 12));
        chk({ctx, ".aempty"},    32'(s_aempty), 32'(m_lvl <= 2));
        chk({ctx, ".overflow"},  32'(s_ovf),    32'(m_ovf));
        chk({ctx, ".underflow"}, 32'(s_udf),    32'(m_udf));
        chk({ctx, ".rd_valid"},  32'(s_rv),     32'(m_rv));
        chk({ctx, ".dout"},      32'(s_dout),   32'(m_dout));
    endtask

    // One clock of stimulus on the standard instance; expected data is queued
    // on accepted writes and popped when rd_valid is due.
    task automatic step_std(input string ctx, input logic w, input logic [7:0] d,
                            input logic r, input logic f, input logic c);
        logic wacc, racc;
        s_wr = w; s_din = d; s_rd = r; s_flush = f; s_clr = c;
        wacc  = w && (m_lvl != 16) && !f;
        racc  = r && (m_lvl != 0)  && !f;
        m_ovf = (m_ovf && !c) || (w && (m_lvl == 16) && !f);
        m_udf = (m_udf && !c) || (r && (m_lvl == 0)  && !f);
        if (f) begin
            sb.delete();
            m_lvl = 0;
            m_rv  = 1'b0;
        end else begin
            if (wacc) sb.push_back(d);
            m_lvl = m_lvl + int'(wacc) - int'(racc);
            m_rv  = racc;
        end
        @(posedge clk);
        #1;
        s_wr = 0; s_rd = 0; s_flush = 0; s_clr = 0;
        if (m_rv) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s.scoreboard: got empty queue expected data", ctx);
            end else begin
                m_dout = sb.pop_front();
            end
        end
        check_std(ctx);
    endtask

    task automatic model_reset();
        sb.delete();
        m_lvl = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_dout = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        s_wr = 0; s_rd = 0; s_flush = 0; s_clr = 0; s_din = 8'h00;
        f_wr = 0; f_rd = 0; f_flush = 0; f_clr = 0; f_din = 8'h00;
        model_reset();

        #12;
        check_std("reset");
        chk("reset.fwft_rd_valid", 32'(f_rv),    32'd0);
        chk("reset.fwft_empty",    32'(f_empty), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // fill with 0x11..0x20, one overflowing write, then drain
        for (int i = 0; i < 16; i++) step_std("fill16", 1, 8'(8'h11 + i), 0, 0, 0);
        step_std("overflow_write", 1, 8'hAA, 0, 0, 0);
        for (int i = 0; i < 16; i++) step_std("drain16", 0, 8'h00, 1, 0, 0);
        step_std("idle_after_drain", 0, 8'h00, 0, 0, 0);
        step_std("clr_ovf", 0, 8'h00, 0, 0, 1);

        // level 5 then simultaneous traffic across pointer wrap
        for (int i = 0; i < 5; i++)  step_std("fill5", 1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step_std("wr_rd", 1, 8'(8'h60 + i), 1, 0, 0);
        for (int i = 0; i < 5; i++)  step_std("drain5", 0, 8'h00, 1, 0, 0);

        // full FIFO with simultaneous read and write
        for (int i = 0; i < 16; i++) step_std("refill16", 1, 8'(8'h80 + i), 0, 0, 0);
        step_std("full_wr_rd", 1, 8'h55, 1, 0, 0);
        step_std("clr_ovf2", 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 15; i++) step_std("drain15", 0, 8'h00, 1, 0, 0);
        step_std("idle2", 0, 8'h00, 0, 0, 0);

        // underflow, clear, clear racing a new underflow
        step_std("underflow", 0, 8'h00, 1, 0, 0);
        step_std("clr_udf", 0, 8'h00, 0, 0, 1);
        step_std("clr_and_udf", 0, 8'h00, 1, 0, 1);
        step_std("clr_udf2", 0, 8'h00, 0, 0, 1);

        // flush beats wr_en and rd_en at level 9
        for (int i = 0; i < 9; i++) step_std("fill9", 1, 8'(8'hC0 + i), 0, 0, 0);
        step_std("flush", 1, 8'hEE, 1, 1, 0);
        step_std("after_flush_wr", 1, 8'hD1, 0, 0, 0);
        step_std("after_flush_rd", 0, 8'h00, 1, 0, 0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step_std("prefill", 1, 8'(8'hB0 + i), 0, 0, 0);
        step_std("pre_reset_rd", 0, 8'h00, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_std("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step_std("post_reset_wr", 1, 8'h5A, 0, 0, 0);
        step_std("post_reset_rd", 0, 8'h00, 1, 0, 0);

        // FWFT instance: head word visible without rd_en
        f_wr = 1; f_din = 8'h3C;
        @(posedge clk); #1;
        f_wr = 0;
        chk("fwft.dout",     32'(f_dout),  32'h3C);
        chk("fwft.rd_valid", 32'(f_rv),    32'd1);
        chk("fwft.level",    32'(f_level), 32'd1);
        f_rd = 1;
        @(posedge clk); #1;
        f_rd = 0;
        chk("fwft.pop_empty",    32'(f_empty), 32'd1);
        chk("fwft.pop_rd_valid", 32'(f_rv),    32'd0);
        f_wr = 1; f_din = 8'hA1;
        @(posedge clk); #1;
        f_din = 8'hA2;
        @(posedge clk); #1;
        f_wr = 0;
        chk("fwft.head1", 32'(f_dout), 32'hA1);
        f_rd = 1;
        @(posedge clk); #1;
        f_rd = 0;
        chk("fwft.head2",  32'(f_dout),  32'hA2);
        chk("fwft.level2", 32'(f_level), 32'd1);
        chk("fwft.errors", 32'({f_ovf, f_udf}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
